// File: rtl/hazard_ctrl_md_pkg.sv
// Shared decode definitions for the D-stage hazard unit: opcode/funct constants,
// Tuse/Tnew codes, the decoded-instruction record and the class decode function.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package hazard_ctrl_md_pkg;

  // Source-use times (cycles from D until the operand is consumed)
  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  // Result-ready times as seen when the producer sits in E
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [4:0] REG_RA  = 5'd31;
  localparam logic [4:0] EPC_REG = 5'd14;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // COP0 rs sub-codes and the full eret encoding
  localparam logic [4:0]  CP0_MF     = 5'd0;
  localparam logic [4:0]  CP0_MT     = 5'd4;
  localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

  typedef struct packed {
    logic       use_rs;
    logic [1:0] tuse_rs;
    logic       use_rt;
    logic [1:0] tuse_rt;
    logic [4:0] dst;      // 0 means no register write
    logic [1:0] tnew;     // Tnew once the instruction reaches E
    logic       is_mult;
    logic       is_div;
    logic       md_use;   // touches HI/LO: mult/div/mfhi/mflo/mthi/mtlo
    logic       epc_wr;   // mtc0 targeting EPC
    logic       is_eret;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    op = instr[31:26];
    rs = instr[25:21];
    rt = instr[20:16];
    rd = instr[15:11];
    fn = instr[5:0];
    d  = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_JR: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_0;
          end
          FN_JALR: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_0;
            d.dst = rd; d.tnew = TNEW_0;
          end
          FN_MFHI, FN_MFLO: begin
            d.dst = rd; d.tnew = TNEW_1; d.md_use = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_1; d.md_use = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
            d.use_rt = 1'b1; d.tuse_rt = TUSE_1;
            d.is_mult = 1'b1; d.md_use = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
            d.use_rt = 1'b1; d.tuse_rt = TUSE_1;
            d.is_div = 1'b1; d.md_use = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
            d.use_rt = 1'b1; d.tuse_rt = TUSE_1;
            d.dst = rd; d.tnew = TNEW_1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_0;
        // bltzal/bgezal link into $ra
        if (rt[4]) begin
          d.dst = REG_RA; d.tnew = TNEW_0;
        end
      end
      OP_BEQ, OP_BNE: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_0;
        d.use_rt = 1'b1; d.tuse_rt = TUSE_0;
      end
      OP_BLEZ, OP_BGTZ: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_0;
      end
      OP_JAL: begin
        d.dst = REG_RA; d.tnew = TNEW_0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
        d.dst = rt; d.tnew = TNEW_1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
        d.dst = rt; d.tnew = TNEW_2;
      end
      OP_SB, OP_SH, OP_SW: begin
        d.use_rs = 1'b1; d.tuse_rs = TUSE_1;
        d.use_rt = 1'b1; d.tuse_rt = TUSE_2;
      end
      OP_COP0: begin
        if (instr == ERET_INSTR) begin
          d.is_eret = 1'b1;
        end else if (rs == CP0_MF) begin
          d.dst = rt; d.tnew = TNEW_2;
        end else if (rs == CP0_MT) begin
          d.epc_wr = (rd == EPC_REG);
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_md_busy_ctr.sv
// HI/LO busy counter: loads LAT-1 when a mult/div sits in E, else counts down to 0.
// Latency: busy asserts combinationally while the op is in E, then for LAT-1 more cycles.
// Backpressure: none; the counter always runs and is only cleared by reset.
// Ports: clk, reset (sync, active-low), ld_mult, ld_div (op in E), md_busy.
module md_busy_ctr #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int MD_CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_mult,
  input  logic ld_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_LAT - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_LAT - 1);

  logic [MD_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ld_div) begin
      cnt <= DIV_LD;
    end else if (ld_mult) begin
      cnt <= MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The cycle the op is in E counts as busy too, so total busy time is LAT.
  assign md_busy = (cnt != '0) | ld_mult | ld_div;

endmodule

// File: rtl/hazard_ctrl_md.sv
// D-stage hazard unit: decodes Instr_D, tracks E/M destinations and Tnew, HI/LO busy, eret/EPC.
// Latency: stall outputs are combinational from tracker state and Instr_D; trackers update each clk.
// Backpressure: Stall_PC/Stall_D hold fetch/decode and Flush_E injects a bubble; Flush_All overrides.
// Ports: clk, reset (sync, active-low), Instr_D, Flush_All -> Stall_PC, Stall_D, Flush_E, MD_Busy,
//        Tnew_E, Write_Addr_E. Macro HAZ_STATS_EN adds Stall_Cnt_RAW/MD/ERET (32-bit cycle counters).
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int MD_CNT_W = 4,
  parameter int TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr_D,
  input  logic              Flush_All,
  output logic              Stall_PC,
  output logic              Stall_D,
  output logic              Flush_E,
  output logic              MD_Busy,
  output logic [TNEW_W-1:0] Tnew_E,
  output logic [4:0]        Write_Addr_E
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       Stall_Cnt_RAW,
  output logic [31:0]       Stall_Cnt_MD,
  output logic [31:0]       Stall_Cnt_ERET
`endif
);

  dec_t dec_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;

  assign dec_d = decode_instr(Instr_D);
  assign rs_d  = Instr_D[25:21];
  assign rt_d  = Instr_D[20:16];

  // Tracker slots. W is not stored: its result is always forwardable, so
  // nothing downstream of M can cause a stall and M simply retires.
  logic [4:0]        addr_e, addr_m;
  logic [TNEW_W-1:0] tnew_e, tnew_m;
  logic              mult_e, div_e;
  logic              epc_e, epc_m;

  logic md_busy;
  logic raw_stall, md_stall, eret_stall, stall;

  function automatic logic slot_hit(input logic [4:0]        a,
                                    input logic [TNEW_W-1:0] t,
                                    input logic [4:0]        s,
                                    input logic [1:0]        u);
    return (a == s) && (a != 5'd0) && (32'(t) > 32'(u));
  endfunction

  function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  md_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .MD_CNT_W (MD_CNT_W)
  ) u_md_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .ld_mult (mult_e),
    .ld_div  (div_e),
    .md_busy (md_busy)
  );

  always_comb begin
    raw_stall  = 1'b0;
    md_stall   = 1'b0;
    eret_stall = 1'b0;
    if (dec_d.use_rs) begin
      raw_stall = raw_stall
                | slot_hit(addr_e, tnew_e, rs_d, dec_d.tuse_rs)
                | slot_hit(addr_m, tnew_m, rs_d, dec_d.tuse_rs);
    end
    if (dec_d.use_rt) begin
      raw_stall = raw_stall
                | slot_hit(addr_e, tnew_e, rt_d, dec_d.tuse_rt)
                | slot_hit(addr_m, tnew_m, rt_d, dec_d.tuse_rt);
    end
    md_stall   = md_busy & dec_d.md_use;
    eret_stall = dec_d.is_eret & (epc_e | epc_m);
  end

  // A redirect kills the instruction in D anyway, so holding it is pointless.
  assign stall = (raw_stall | md_stall | eret_stall) & ~Flush_All;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_e <= '0;
      tnew_e <= '0;
      mult_e <= 1'b0;
      div_e  <= 1'b0;
      epc_e  <= 1'b0;
      addr_m <= '0;
      tnew_m <= '0;
      epc_m  <= 1'b0;
    end else begin
      if (Flush_All) begin
        addr_m <= '0;
        tnew_m <= '0;
        epc_m  <= 1'b0;
      end else begin
        addr_m <= addr_e;
        tnew_m <= tnew_step(tnew_e);
        epc_m  <= epc_e;
      end
      if (Flush_All || stall) begin
        addr_e <= '0;
        tnew_e <= '0;
        mult_e <= 1'b0;
        div_e  <= 1'b0;
        epc_e  <= 1'b0;
      end else begin
        addr_e <= dec_d.dst;
        tnew_e <= TNEW_W'(dec_d.tnew);
        mult_e <= dec_d.is_mult;
        div_e  <= dec_d.is_div;
        epc_e  <= dec_d.epc_wr;
      end
    end
  end

`ifdef HAZ_STATS_EN
  // Causes are counted as seen on the outputs, i.e. after redirect suppression.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Stall_Cnt_RAW  <= '0;
      Stall_Cnt_MD   <= '0;
      Stall_Cnt_ERET <= '0;
    end else if (!Flush_All) begin
      if (raw_stall)  Stall_Cnt_RAW  <= Stall_Cnt_RAW + 32'd1;
      if (md_stall)   Stall_Cnt_MD   <= Stall_Cnt_MD + 32'd1;
      if (eret_stall) Stall_Cnt_ERET <= Stall_Cnt_ERET + 32'd1;
    end
  end
`endif

  assign Stall_D      = stall;
  assign Stall_PC     = stall;
  assign Flush_E      = stall;
  assign MD_Busy      = md_busy;
  assign Tnew_E       = tnew_e;
  assign Write_Addr_E = addr_e;

endmodule
